mips_dump_serializer: RTL and testbench

MIPS_DUMP_SERIALIZER -- requirements
Module: mips_dump_serializer

---
 rtl/mips_dump_serializer.sv | 96 +++++++++
 tb/tb_mips_dump_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dump_serializer.sv
// Streams a frozen PC / register-bank / data-memory snapshot into a UART TX FIFO,
// one byte per accepted write, each word most-significant byte first.
module mips_dump_word_split #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic [WORD_W-1:0]                    word,
    output logic [WORD_W/BYTE_W-1:0][BYTE_W-1:0] byte_seq
);
    // byte_seq[0] is the first byte on the wire, i.e. the word's MSB
    for (genvar b = 0; b < WORD_W/BYTE_W; b++) begin : g_byte
        assign byte_seq[b] = word[WORD_W-1-b*BYTE_W -: BYTE_W];
    end
endmodule

module mips_dump_serializer #(
    parameter int UART_BUS_SIZE          = 8,
    parameter int REGISTER_SIZE          = 32,
    parameter int REGISTER_BANK_BUS_SIZE = 1024,
    parameter int MEMORY_DATA_BUS_SIZE   = 1024
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_start,
    input  logic                              i_uart_full,
    input  logic [REGISTER_SIZE-1:0]          i_current_pc,
    input  logic [REGISTER_BANK_BUS_SIZE-1:0] i_registers,
    input  logic [MEMORY_DATA_BUS_SIZE-1:0]   i_memory,
    output logic                              o_uart_wr,
    output logic [UART_BUS_SIZE-1:0]          o_uart_data,
    output logic                              o_busy,
    output logic                              o_done
);
    localparam int BPW     = REGISTER_SIZE / 8;
    localparam int N_REGS  = REGISTER_BANK_BUS_SIZE / REGISTER_SIZE;
    localparam int N_MEM   = MEMORY_DATA_BUS_SIZE / REGISTER_SIZE;
    localparam int N_WORDS = 1 + N_REGS + N_MEM;
    localparam int NBYTES  = BPW * N_WORDS;
    localparam int IDX_W   = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                               state;
    logic [IDX_W-1:0]                         idx;
    logic [N_WORDS-1:0][REGISTER_SIZE-1:0]    snap;
    logic [N_WORDS-1:0][BPW-1:0][7:0]         snap_bytes;
    logic [NBYTES-1:0][7:0]                   stream;

    for (genvar w = 0; w < N_WORDS; w++) begin : g_word
        mips_dump_word_split #(
            .WORD_W (REGISTER_SIZE),
            .BYTE_W (8)
        ) u_split (
            .word     (snap[w]),
            .byte_seq (snap_bytes[w])
        );
    end

    // word-major packing makes stream[i] the i-th byte on the wire
    assign stream = snap_bytes;

    assign o_uart_wr   = (state == S_SEND) && !i_uart_full;
    assign o_uart_data = (state == S_SEND) ? UART_BUS_SIZE'(stream[idx]) : '0;
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
            idx   <= '0;
            snap  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        // word 0 = PC, then registers, then memory
                        snap  <= {i_memory, i_registers, i_current_pc};
                        idx   <= '0;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (o_uart_wr) begin
                        if (idx == LAST_IDX) state <= S_DONE;
                        else                 idx   <= idx + IDX_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_dump_serializer.sv
// Scoreboard bench for mips_dump_serializer: expected bytes are queued from a
// reference model at start time and compared against the captured write stream.
module tb_mips_dump_serializer;
    localparam int NB = 260;

    logic          clk = 1'b0;
    logic          rst, start, full;
    logic [31:0]   pc;
    logic [1023:0] regs, mem;
    logic          wr, busy, done;
    logic [7:0]    data;

    int checks = 0, failures = 0, cyc = 0, start_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         done_q[$];
    logic [7:0] first12 [12] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [7:0] last4 [4] = '{8'hA0, 8'h00, 8'h00, 8'h1F};

    mips_dump_serializer dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_uart_full  (full),
        .i_current_pc (pc),
        .i_registers  (regs),
        .i_memory     (mem),
        .o_uart_wr    (wr),
        .o_uart_data  (data),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_byte(input int i, input logic [31:0] p,
                                              input logic [1023:0] r, input logic [1023:0] m);
        int w = i / 4;
        int b = i % 4;
        logic [31:0] word;
        if (w == 0)       word = p;
        else if (w <= 32) word = r[(w-1)*32 +: 32];
        else              word = m[(w-33)*32 +: 32];
        return word[31-8*b -: 8];
    endfunction

    task automatic push_expected();
        for (int i = 0; i < NB; i++) exp_q.push_back(model_byte(i, pc, regs, mem));
    endtask

    task automatic set_basic();
        pc = 32'h0000_0010;
        for (int k = 0; k < 32; k++) begin
            regs[k*32 +: 32] = 32'(k);
            mem[k*32 +: 32]  = 32'hA000_0000 + 32'(k);
        end
    endtask

    // inputs change at the falling edge, outputs are observed 1ns later and
    // stay valid through the following rising edge
    task automatic cycle(input logic f, input logic s);
        @(negedge clk);
        full  = f;
        start = s;
        #1;
        if (wr)   got_q.push_back(data);
        if (done) done_q.push_back(cyc);
    endtask

    task automatic start_dump();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        start_cyc = cyc;
    endtask

    task automatic run_to_done();
        for (int c = 0; c < 2000 && done_q.size() == 0; c++) cycle(1'b0, 1'b0);
    endtask

    task automatic clear_all();
        exp_q.delete();
        got_q.delete();
        done_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; full = 1'b0; pc = '0; regs = '0; mem = '0;
        #3;
        checks++;
        if ({wr, data, busy, done} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs got wr=%b data=%02h busy=%b done=%b exp all 0", wr, data, busy, done);
        end
        set_basic();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        checks++;
        if ({wr, data, busy, done} !== 11'b0) begin
            failures++;
            $display("FAIL reset_held got wr=%b data=%02h busy=%b done=%b exp all 0", wr, data, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0);
        checks++;
        if (got_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_auto_start got writes=%0d busy=%b exp 0 0", got_q.size(), busy);
        end
        clear_all();
    endtask

    task automatic test_basic();
        logic [7:0] g, e;
        int k = 0;
        set_basic();
        push_expected();
        start_dump();
        run_to_done();
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0);
        checks++;
        if (got_q.size() != NB) begin
            failures++;
            $display("FAIL basic_len got=%0d exp=%0d", got_q.size(), NB);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got_q[i] !== first12[i]) begin
                failures++;
                $display("FAIL basic_first[%0d] got=%02h exp=%02h", i, got_q[i], first12[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[NB-4+i] !== last4[i]) begin
                failures++;
                $display("FAIL basic_last[%0d] got=%02h exp=%02h", i, got_q[NB-4+i], last4[i]);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] - start_cyc != NB) begin
            failures++;
            $display("FAIL basic_done_timing got pulses=%0d delta=%0d exp 1 %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] - start_cyc : -1, NB);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_after got=%b exp=0", busy);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL basic_byte[%0d] got=%02h exp=%02h", k, g, e); end
            k++;
        end
        clear_all();
    endtask

    task automatic test_backpressure();
        logic [7:0] g, e;
        logic f;
        int stall = 0, k = 0;
        set_basic();
        push_expected();
        start_dump();
        for (int c = 0; c < 2000 && done_q.size() == 0; c++) begin
            f = (got_q.size() == 7) && (stall < 5);
            cycle(f, 1'b0);
            if (f) begin
                stall++;
                checks++;
                if (wr !== 1'b0 || data !== exp_q[7]) begin
                    failures++;
                    $display("FAIL bp_stall[%0d] got wr=%b data=%02h exp wr=0 data=%02h", stall, wr, data, exp_q[7]);
                end
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] - start_cyc != NB + 5) begin
            failures++;
            $display("FAIL bp_done_timing got pulses=%0d delta=%0d exp 1 %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] - start_cyc : -1, NB + 5);
        end
        checks++;
        if (got_q.size() != NB) begin
            failures++;
            $display("FAIL bp_len got=%0d exp=%0d", got_q.size(), NB);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL bp_byte[%0d] got=%02h exp=%02h", k, g, e); end
            k++;
        end
        clear_all();
    endtask

    task automatic test_isolation();
        logic [7:0] g, e;
        int k = 0;
        set_basic();
        push_expected();
        start_dump();
        pc = '1; regs = '1; mem = '1;
        run_to_done();
        checks++;
        if (got_q.size() != NB) begin
            failures++;
            $display("FAIL iso_len got=%0d exp=%0d", got_q.size(), NB);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL iso_byte[%0d] got=%02h exp=%02h", k, g, e); end
            k++;
        end
        cycle(1'b0, 1'b0);
        clear_all();
    endtask

    task automatic test_start_busy();
        logic [7:0] g, e;
        int k = 0;
        set_basic();
        pc = 32'h0040_0abc;
        push_expected();
        start_dump();
        for (int c = 0; c < 2000 && done_q.size() == 0; c++) cycle(1'b0, got_q.size() == 100);
        for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0);
        checks++;
        if (done_q.size() != 1 || got_q.size() != NB) begin
            failures++;
            $display("FAIL busy_start got pulses=%0d bytes=%0d exp 1 %0d", done_q.size(), got_q.size(), NB);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL busy_byte[%0d] got=%02h exp=%02h", k, g, e); end
            k++;
        end
        clear_all();
    endtask

    task automatic test_reset_mid();
        logic [7:0] g, e;
        int k = 0;
        pc = 32'h1234_5678;
        for (int i = 0; i < 32; i++) begin
            regs[i*32 +: 32] = $urandom;
            mem[i*32 +: 32]  = $urandom;
        end
        push_expected();
        start_dump();
        for (int c = 0; c < 400 && got_q.size() < 50; c++) cycle(1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({wr, data, busy, done} !== 11'b0) begin
            failures++;
            $display("FAIL rstmid_immediate got wr=%b data=%02h busy=%b done=%b exp all 0", wr, data, busy, done);
        end
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0);
        checks++;
        if (got_q.size() != 50 || busy !== 1'b0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_quiet got bytes=%0d busy=%b pulses=%0d exp 50 0 0", got_q.size(), busy, done_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL rstmid_byte[%0d] got=%02h exp=%02h", k, g, e); end
            k++;
        end
        clear_all();
        k = 0;
        pc = 32'hCAFE_0001;
        push_expected();
        start_dump();
        run_to_done();
        checks++;
        if (got_q.size() != NB || done_q.size() != 1 || done_q[0] - start_cyc != NB) begin
            failures++;
            $display("FAIL rstmid_redump got bytes=%0d pulses=%0d exp %0d 1", got_q.size(), done_q.size(), NB);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL redump_byte[%0d] got=%02h exp=%02h", k, g, e); end
            k++;
        end
        cycle(1'b0, 1'b0);
        clear_all();
    endtask

    task automatic test_back_to_back();
        logic [7:0] g, e;
        int k = 0;
        set_basic();
        push_expected();
        push_expected();
        cycle(1'b0, 1'b1);
        for (int c = 0; c < 2000 && done_q.size() < 2; c++) cycle(1'b0, 1'b1);
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0);
        checks++;
        if (!(done_q.size() == 2 && done_q[1] - done_q[0] == NB + 2)) begin
            failures++;
            $display("FAIL b2b_done got pulses=%0d gap=%0d exp 2 %0d",
                     done_q.size(), (done_q.size() == 2) ? done_q[1] - done_q[0] : -1, NB + 2);
        end
        checks++;
        if (got_q.size() != 2*NB) begin
            failures++;
            $display("FAIL b2b_len got=%0d exp=%0d", got_q.size(), 2*NB);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL b2b_byte[%0d] got=%02h exp=%02h", k, g, e); end
            k++;
        end
        clear_all();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_isolation();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
